// File: rtl/aes_masking_reseed_ctrl.sv
// Gates AES block starts and reseeds the masking PRNG from EDN when the block counter expires or a reseed is forced.
// Latency: a non-expired start is granted the next cycle; an expired start is granted one cycle after the last EDN word.
// Backpressure: block_start_i is held until block_go_o; entropy_req_o is held until each ack; waiting for ack stalls the controller.
module aes_masking_reseed_ctrl #(
  parameter int EntropyWidth = 32,
  parameter int StateWidth   = 177,
  parameter int NumParts     = (StateWidth + EntropyWidth - 1) / EntropyWidth,
  parameter int PartIdxW     = $clog2(NumParts),
  parameter int CtrWidth     = 13
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    block_start_i,
  output logic                    block_go_o,
  input  logic [1:0]              reseed_rate_i,
  input  logic                    reseed_force_i,
  output logic                    entropy_req_o,
  input  logic                    entropy_ack_i,
  input  logic [EntropyWidth-1:0] entropy_i,
  output logic                    prng_seed_valid_o,
  output logic [PartIdxW-1:0]     prng_seed_part_o,
  output logic [EntropyWidth-1:0] prng_seed_data_o,
  output logic                    block_ctr_expr_o,
  input  logic                    alert_fatal_i,
  output logic                    busy_o,
  output logic                    error_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESEED = 2'd1,
    GO     = 2'd2,
    ERROR  = 2'd3
  } state_e;

  localparam logic [PartIdxW-1:0] LastPart = PartIdxW'(NumParts - 1);

  state_e                state_q, state_d;
  logic [CtrWidth-1:0]   ctr_q, ctr_d;
  logic [CtrWidth-1:0]   reload;
  logic [PartIdxW-1:0]   part_q, part_d;
  logic                  force_pend_q, force_pend_d;

  // Blocks between reseeds, minus the block granted right after the reseed itself.
  always_comb begin
    reload = '0;
    unique case (reseed_rate_i)
      2'd0:    reload = '0;
      2'd1:    reload = CtrWidth'(63);
      default: reload = CtrWidth'(8191);
    endcase
  end

  // Next-state, counter/part updates and handshake-qualified outputs.
  always_comb begin
    state_d           = state_q;
    ctr_d             = ctr_q;
    part_d            = part_q;
    force_pend_d      = force_pend_q;
    block_go_o        = 1'b0;
    entropy_req_o     = 1'b0;
    prng_seed_valid_o = 1'b0;
    prng_seed_part_o  = '0;
    prng_seed_data_o  = '0;

    unique case (state_q)
      IDLE: begin
        if (block_start_i) begin
          if ((ctr_q == '0) || force_pend_q) begin
            state_d      = RESEED;
            force_pend_d = 1'b0;
          end else begin
            state_d = GO;
            ctr_d   = ctr_q - CtrWidth'(1);
          end
        end
      end
      RESEED: begin
        // Request stays up across wait cycles until the final word is taken.
        entropy_req_o = 1'b1;
        if (entropy_ack_i) begin
          prng_seed_valid_o = 1'b1;
          prng_seed_part_o  = part_q;
          prng_seed_data_o  = entropy_i;
          if (part_q == LastPart) begin
            part_d  = '0;
            ctr_d   = reload;
            state_d = GO;
          end else begin
            part_d = part_q + PartIdxW'(1);
          end
        end
      end
      GO: begin
        block_go_o = 1'b1;
        state_d    = IDLE;
      end
      ERROR: begin
        state_d = ERROR;
      end
    endcase

    // A force seen after the IDLE->RESEED decision must survive to the next block,
    // so it is applied after the clear-on-entry above.
    if (reseed_force_i && (state_q != ERROR)) begin
      force_pend_d = 1'b1;
    end

    // Fatal alert wins over every other transition; a coincident seed write still goes out.
    if (alert_fatal_i) begin
      state_d = ERROR;
    end
  end

  // State registers; reset discards any partially written seed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      ctr_q        <= '0;
      part_q       <= '0;
      force_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctr_q        <= ctr_d;
      part_q       <= part_d;
      force_pend_q <= force_pend_d;
    end
  end

  assign block_ctr_expr_o = (ctr_q == '0);
  assign busy_o           = (state_q != IDLE);
  assign error_o          = (state_q == ERROR);

endmodule
